// File: rtl/clock_freq_pkg.sv
// Shared state encoding and counter widths for the clock frequency reader.
package clock_freq_pkg;

   typedef logic [3:0] state_t;

   localparam state_t ST_IDLE        = 4'd0;
   localparam state_t ST_PRIME_LATCH = 4'd1;
   localparam state_t ST_PRIME_CLR   = 4'd2;
   localparam state_t ST_PRIME_SET   = 4'd3;
   localparam state_t ST_WAIT_PERIOD = 4'd4;
   localparam state_t ST_LATCH       = 4'd5;
   localparam state_t ST_WAIT_CLR    = 4'd6;
   localparam state_t ST_WAIT_SET    = 4'd7;
   localparam state_t ST_CAPTURE     = 4'd8;
   localparam state_t ST_DIVIDE      = 4'd9;
   localparam state_t ST_DONE        = 4'd10;

   localparam int unsigned TMO_CNT_W    = 32'd32;
   localparam int unsigned PERIOD_CNT_W = 32'd32;

endpackage

// File: rtl/clock_freq_reader_serial_divider.sv
// Restoring divider producing one quotient bit per cycle; the first bit is
// resolved on the start cycle so a full divide takes exactly NUM_W cycles.
module serial_divider #(
   parameter int unsigned NUM_W = 32'd96,
   parameter int unsigned DEN_W = 32'd64
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [NUM_W-1:0] i_num,
   input  logic [DEN_W-1:0] i_den,
   output logic             o_done,
   output logic [NUM_W-1:0] o_quot
);

   localparam int unsigned CNT_W = $clog2(NUM_W + 32'd1);

   logic [DEN_W-1:0] rem_r, rem_src_s, rem_nxt_s, diff_s;
   logic [NUM_W-1:0] quo_r, quo_src_s, quo_nxt_s;
   logic [DEN_W:0]   shifted_s;
   logic             ge_s;
   logic [CNT_W-1:0] cnt_r;
   logic             busy_r, done_r;

   // One restoring step: shift in the next dividend bit, keep the subtraction if it fits.
   always_comb begin
      if (i_start) begin
         rem_src_s = {DEN_W{1'b0}};
         quo_src_s = i_num;
      end else begin
         rem_src_s = rem_r;
         quo_src_s = quo_r;
      end
      shifted_s = {rem_src_s, quo_src_s[NUM_W-1]};
      ge_s      = (shifted_s >= {1'b0, i_den});
      diff_s    = shifted_s[DEN_W-1:0] - i_den;
      if (ge_s) begin
         rem_nxt_s = diff_s;
         quo_nxt_s = {quo_src_s[NUM_W-2:0], 1'b1};
      end else begin
         rem_nxt_s = shifted_s[DEN_W-1:0];
         quo_nxt_s = {quo_src_s[NUM_W-2:0], 1'b0};
      end
   end

   // Step counter plus quotient/remainder registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rem_r  <= {DEN_W{1'b0}};
         quo_r  <= {NUM_W{1'b0}};
         cnt_r  <= {CNT_W{1'b0}};
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else if (i_start) begin
         rem_r  <= rem_nxt_s;
         quo_r  <= quo_nxt_s;
         cnt_r  <= CNT_W'(1'b1);
         busy_r <= 1'b1;
         done_r <= 1'b0;
      end else if (busy_r) begin
         rem_r <= rem_nxt_s;
         quo_r <= quo_nxt_s;
         cnt_r <= cnt_r + CNT_W'(1'b1);
         if (cnt_r == CNT_W'(NUM_W - 32'd1)) begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
         end else begin
            done_r <= 1'b0;
         end
      end else begin
         done_r <= 1'b0;
      end
   end

   assign o_done = done_r;
   assign o_quot = quo_r;

endmodule

// File: rtl/clock_freq_reader.sv
// Measures an external clock from a pair of latched free-running counters: a priming
// latch zeroes them, a second latch one period later gives f = F_local * ext / local.
module clock_freq_reader
   import clock_freq_pkg::*;
#(
   parameter int unsigned CLOCK_COUNTER_WIDTH   = 32'd64,
   parameter int unsigned LOCAL_FREQ_HZ         = 32'd100_000_000,
   parameter int unsigned MEASURE_PERIOD_CYCLES = 32'd1_000_000,
   parameter int unsigned FREQ_WIDTH            = 32'd32,
   parameter int unsigned TIMEOUT_CYCLES        = 32'd65_536
) (
   input  logic                           i_clk,
   input  logic                           i_rst,
   input  logic                           i_start,
   input  logic                           i_continuous,
   output logic                           o_latch_counters,
   input  logic                           i_counter_valid,
   input  logic [CLOCK_COUNTER_WIDTH-1:0] i_clk_local_counter,
   input  logic [CLOCK_COUNTER_WIDTH-1:0] i_clk_extern_counter,
   output logic                           o_busy,
   output logic                           o_freq_valid,
   output logic [FREQ_WIDTH-1:0]          o_freq_hz,
   output logic                           o_error
);

   localparam int unsigned NUM_W = CLOCK_COUNTER_WIDTH + 32'd32;
   localparam int unsigned AGE_W = (TMO_CNT_W > PERIOD_CNT_W) ? TMO_CNT_W : PERIOD_CNT_W;

   state_t                         state_r, state_s;
   logic [AGE_W-1:0]               age_r;
   logic [NUM_W-1:0]               num_r, quot_s;
   logic [CLOCK_COUNTER_WIDTH-1:0] den_r;
   logic                           div_start_r, div_done_s;
   logic                           tmo_s, period_end_s;
   logic [FREQ_WIDTH-1:0]          freq_sat_s, freq_hz_r;
   logic                           latch_r, busy_r, freq_valid_r, error_r;

   // age_r counts cycles spent in the current state; it serves both the period and the timeouts
   assign tmo_s        = (age_r == AGE_W'(TIMEOUT_CYCLES - 32'd1));
   assign period_end_s = (age_r == AGE_W'(MEASURE_PERIOD_CYCLES - 32'd1));

   // Next-state decode for the latch / wait / divide sequence.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE:        if (i_start || i_continuous) state_s = ST_PRIME_LATCH; else state_s = ST_IDLE;
         ST_PRIME_LATCH: state_s = ST_PRIME_CLR;
         ST_PRIME_CLR:   if (!i_counter_valid) state_s = ST_PRIME_SET; else if (tmo_s) state_s = ST_IDLE; else state_s = ST_PRIME_CLR;
         ST_PRIME_SET:   if (i_counter_valid) state_s = ST_WAIT_PERIOD; else if (tmo_s) state_s = ST_IDLE; else state_s = ST_PRIME_SET;
         ST_WAIT_PERIOD: if (period_end_s) state_s = ST_LATCH; else state_s = ST_WAIT_PERIOD;
         ST_LATCH:       state_s = ST_WAIT_CLR;
         ST_WAIT_CLR:    if (!i_counter_valid) state_s = ST_WAIT_SET; else if (tmo_s) state_s = ST_IDLE; else state_s = ST_WAIT_CLR;
         ST_WAIT_SET:    if (i_counter_valid) state_s = ST_CAPTURE; else if (tmo_s) state_s = ST_IDLE; else state_s = ST_WAIT_SET;
         ST_CAPTURE:     if (i_clk_local_counter == {CLOCK_COUNTER_WIDTH{1'b0}}) state_s = ST_IDLE; else state_s = ST_DIVIDE;
         ST_DIVIDE:      if (div_done_s) state_s = ST_DONE; else state_s = ST_DIVIDE;
         ST_DONE:        if (i_continuous) state_s = ST_PRIME_LATCH; else state_s = ST_IDLE;
         default:        state_s = ST_IDLE;
      endcase
   end

   // Saturate the wide quotient into the result width.
   always_comb begin
      if (|quot_s[NUM_W-1:FREQ_WIDTH]) begin
         freq_sat_s = {FREQ_WIDTH{1'b1}};
      end else begin
         freq_sat_s = quot_s[FREQ_WIDTH-1:0];
      end
   end

   // Sequence state, strobes, captured operands and result registers.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_r      <= ST_IDLE;
         age_r        <= {AGE_W{1'b0}};
         num_r        <= {NUM_W{1'b0}};
         den_r        <= {CLOCK_COUNTER_WIDTH{1'b0}};
         div_start_r  <= 1'b0;
         latch_r      <= 1'b0;
         busy_r       <= 1'b0;
         freq_valid_r <= 1'b0;
         freq_hz_r    <= {FREQ_WIDTH{1'b0}};
         error_r      <= 1'b0;
      end else begin
         state_r      <= state_s;
         age_r        <= (state_s != state_r) ? {AGE_W{1'b0}} : age_r + AGE_W'(1'b1);
         latch_r      <= (state_s == ST_PRIME_LATCH) || (state_s == ST_LATCH);
         busy_r       <= (state_s != ST_IDLE);
         div_start_r  <= (state_r == ST_CAPTURE) && (state_s == ST_DIVIDE);
         freq_valid_r <= (state_s == ST_DONE);
         if (state_r == ST_CAPTURE) begin
            num_r <= NUM_W'(LOCAL_FREQ_HZ) * NUM_W'(i_clk_extern_counter);
            den_r <= i_clk_local_counter;
         end
         if ((state_r == ST_DIVIDE) && div_done_s) begin
            freq_hz_r <= freq_sat_s;
         end
         // any return to IDLE that is not the normal DONE exit is an abort
         if ((state_s == ST_IDLE) && (state_r != ST_IDLE) && (state_r != ST_DONE)) begin
            error_r <= 1'b1;
         end else if ((state_r == ST_IDLE) && i_start) begin
            error_r <= 1'b0;
         end
      end
   end

   serial_divider #(
      .NUM_W (NUM_W),
      .DEN_W (CLOCK_COUNTER_WIDTH)
   ) u_divider (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_start (div_start_r),
      .i_num   (num_r),
      .i_den   (den_r),
      .o_done  (div_done_s),
      .o_quot  (quot_s)
   );

   assign o_latch_counters = latch_r;
   assign o_busy           = busy_r;
   assign o_freq_valid     = freq_valid_r;
   assign o_freq_hz        = freq_hz_r;
   assign o_error          = error_r;

endmodule
